// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider FSM states, opcode, flag indices,
// canonical NaN, exponent bias and an operand unpack helper (DAZ).
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        ROUND,
        DONE
    } div_state_e;

    localparam logic [4:0]  FDIV_OP   = 5'b01101;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;

    // 24 mantissa bits plus guard and round
    localparam int ITER_CYCLES = 26;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
        logic        is_snan;
    } fp_unpk_t;

    // Subnormals collapse to signed zero; hidden bit restored otherwise.
    function automatic fp_unpk_t fp_unpack(input logic [31:0] x);
        fp_unpk_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.is_zero = ~|x[30:23];
        u.is_nan  = (&x[30:23]) & (|x[22:0]);
        u.is_snan = u.is_nan & ~x[22];
        u.is_inf  = (&x[30:23]) & ~(|x[22:0]);
        u.mant    = u.is_zero ? 24'h0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpu_div_round.sv
// Divider back end: round-to-nearest-even, carry renormalisation,
// overflow to infinity, flush-to-zero underflow, and IEEE packing.
// Ports: sign/exp/mant/guard/rnd/sticky in; packed result and flags out.
module fpu_div_round
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp,
    input  logic [23:0]       mant,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    output logic [31:0]       result,
    output logic [4:0]        flags
);

    logic              up;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] exp_n;
    logic              inexact;

    always_comb begin
        up      = guard & (rnd | sticky | mant[0]);
        sum     = {1'b0, mant} + {24'h0, up};
        inexact = guard | rnd | sticky;
        // carry out means the mantissa rolled to 2.0: shift and bump exp
        if (sum[24]) begin
            frac  = sum[23:1];
            exp_n = exp + 10'sd1;
        end else begin
            frac  = sum[22:0];
            exp_n = exp;
        end

        flags          = '0;
        result         = {sign, exp_n[7:0], frac};
        flags[FLAG_NX] = inexact;

        if (exp_n >= 10'sd255) begin
            result         = {sign, 8'hFF, 23'h0};
            flags[FLAG_OF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            result         = {sign, 31'h0};
            flags[FLAG_UF] = 1'b1;
            flags[FLAG_NX] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_div_iter.sv
// Iterative single-precision divider: one restoring quotient bit per cycle.
// Ports: i_clk, i_reset, i_start, i_flush, i_rs1/2_data in;
// o_busy, o_valid, o_result, o_flags out.
module fpu_div_iter
    import fpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [4:0]  o_flags
);

    div_state_e state_q, state_d;

    logic [4:0]        cnt_q;
    logic [31:0]       opa_q, opb_q;
    logic [25:0]       rem_q;
    logic [23:0]       divs_q;
    logic [25:0]       quo_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [31:0]       pend_res_q, last_res_q;
    logic [4:0]        pend_flg_q, last_flg_q;

    fp_unpk_t ua, ub;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [4:0]  spec_flg;
    logic        s_res;

    logic              qbit;
    logic [25:0]       rem_nxt;
    logic              norm;
    logic [23:0]       r_mant;
    logic              r_guard, r_rnd, r_sticky;
    logic signed [9:0] r_exp;
    logic [31:0]       rnd_res;
    logic [4:0]        rnd_flg;

    // ---------------- special-case classification ----------------
    always_comb begin
        ua       = fp_unpack(opa_q);
        ub       = fp_unpack(opb_q);
        s_res    = ua.sign ^ ub.sign;
        spec_hit = 1'b1;
        spec_flg = '0;
        spec_res = {s_res, 31'h0};
        if (ua.is_nan || ub.is_nan) begin
            spec_res          = CANON_NAN;
            spec_flg[FLAG_NV] = ua.is_snan | ub.is_snan;
        end else if ((ua.is_inf && ub.is_inf) ||
                     (ua.is_zero && ub.is_zero)) begin
            spec_res          = CANON_NAN;
            spec_flg[FLAG_NV] = 1'b1;
        end else if (ua.is_inf) begin
            spec_res = {s_res, 8'hFF, 23'h0};
        end else if (ub.is_inf || ua.is_zero) begin
            spec_res = {s_res, 31'h0};
        end else if (ub.is_zero) begin
            spec_res          = {s_res, 8'hFF, 23'h0};
            spec_flg[FLAG_DZ] = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ---------------- restoring step ----------------
    always_comb begin
        qbit    = rem_q >= {2'b00, divs_q};
        rem_nxt = (qbit ? rem_q - {2'b00, divs_q} : rem_q) << 1;
    end

    // Quotient lies in (0.5, 2): bit 25 set means no normalisation shift.
    // When shifting, the round bit is the next quotient bit (qbit).
    always_comb begin
        norm     = quo_q[25];
        r_mant   = norm ? quo_q[25:2] : quo_q[24:1];
        r_guard  = norm ? quo_q[1] : quo_q[0];
        r_rnd    = norm ? quo_q[0] : qbit;
        r_sticky = |rem_q;
        r_exp    = norm ? exp_q : exp_q - 10'sd1;
    end

    fpu_div_round u_round (
        .sign   (sign_q),
        .exp    (r_exp),
        .mant   (r_mant),
        .guard  (r_guard),
        .rnd    (r_rnd),
        .sticky (r_sticky),
        .result (rnd_res),
        .flags  (rnd_flg)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (i_start) state_d = PREP;
            PREP:  state_d = spec_hit ? DONE : ITER;
            ITER:  if (cnt_q == 5'(ITER_CYCLES - 1)) state_d = ROUND;
            ROUND: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush && state_q != IDLE) state_d = IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rem_q      <= '0;
            divs_q     <= '0;
            quo_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            pend_res_q <= '0;
            pend_flg_q <= '0;
            last_res_q <= '0;
            last_flg_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        opa_q <= i_rs1_data;
                        opb_q <= i_rs2_data;
                    end
                end
                PREP: begin
                    rem_q  <= {2'b00, ua.mant};
                    divs_q <= ub.mant;
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    sign_q <= s_res;
                    exp_q  <= $signed({2'b00, ua.exp})
                            - $signed({2'b00, ub.exp}) + EXP_BIAS;
                    if (spec_hit) begin
                        pend_res_q <= spec_res;
                        pend_flg_q <= spec_flg;
                    end
                end
                ITER: begin
                    quo_q <= {quo_q[24:0], qbit};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 5'd1;
                end
                ROUND: begin
                    pend_res_q <= rnd_res;
                    pend_flg_q <= rnd_flg;
                end
                DONE: begin
                    if (!i_flush) begin
                        last_res_q <= pend_res_q;
                        last_flg_q <= pend_flg_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // A flush landing in DONE suppresses the strobe and the update.
    assign o_busy   = state_q != IDLE;
    assign o_valid  = (state_q == DONE) && !i_flush;
    assign o_result = o_valid ? pend_res_q : last_res_q;
    assign o_flags  = o_valid ? pend_flg_q : last_flg_q;

endmodule

// File: tb/tb_fpu_div_iter.sv
// Directed bench for fpu_div_iter: normal, special, flush, busy-start
// and asynchronous reset scenarios against hand-computed results.
module tb_fpu_div_iter;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        i_flush;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_flags;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NX   = 5'b00001;
    localparam logic [4:0] F_DZ   = 5'b01000;
    localparam logic [4:0] F_NV   = 5'b10000;
    localparam logic [4:0] F_OFNX = 5'b00101;
    localparam logic [4:0] F_UFNX = 5'b00011;

    fpu_div_iter dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_flush    (i_flush),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_flags    (o_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // start sampled at the posedge this task waits on (edge n)
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_rs1_data = a;
        i_rs2_data = b;
        i_start    = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // returns edges after n until o_valid; 0 on timeout
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) lat = i;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eres,
                          input logic [4:0] eflg, input int elat);
        int lat;
        launch(a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_res"}, o_result, eres);
        check({tag, "_flg"}, {27'h0, o_flags}, {27'h0, eflg});
        @(posedge i_clk);
        #1;
        check({tag, "_vld_drop"}, {31'h0, o_valid}, 32'h0);
        check({tag, "_busy_drop"}, {31'h0, o_busy}, 32'h0);
        check({tag, "_hold"}, o_result, eres);
    endtask

    initial begin
        int lat;
        int seen;
        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_flush    = 1'b0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        #12;
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_res", o_result, 32'h0);
        check("rst_flg", {27'h0, o_flags}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        run_op("div6_2", 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 28);
        run_op("div1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NX, 28);
        run_op("dz", 32'h3F800000, 32'h00000000, 32'h7F800000, F_DZ, 1);
        run_op("z_z", 32'h00000000, 32'h80000000, 32'h7FC00000, F_NV, 1);
        run_op("ovf", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, F_OFNX, 28);
        run_op("unf", 32'h00800000, 32'h40000000, 32'h00000000, F_UFNX, 28);

        // i_start while busy must not disturb the running divide
        launch(32'h40C00000, 32'h40000000);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        i_rs1_data = 32'h3F800000;
        i_rs2_data = 32'h40400000;
        i_start    = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_start = 1'b0;
        check("busy_mid", {31'h0, o_busy}, 32'h1);
        wait_valid(lat);
        check("ign_lat", 32'(lat), 32'd20);
        check("ign_res", o_result, 32'h40400000);
        @(posedge i_clk);
        #1;

        // flush in ITER cycle 10
        launch(32'h3F800000, 32'h40400000);
        repeat (11) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("fl_busy", {31'h0, o_busy}, 32'h0);
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        check("fl_novalid", 32'(seen), 32'h0);
        check("fl_res", o_result, 32'h40400000);
        check("fl_flg", {27'h0, o_flags}, 32'h0);

        // flush arriving in DONE beats completion
        launch(32'h3F800000, 32'h00000000);
        @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        #1;
        check("fd_valid", {31'h0, o_valid}, 32'h0);
        check("fd_res", o_result, 32'h40400000);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("fd_busy", {31'h0, o_busy}, 32'h0);
        check("fd_hold", o_result, 32'h40400000);

        // asynchronous reset mid-ITER
        launch(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge i_clk);
        #3;
        i_reset = 1'b1;
        #1;
        check("ar_busy", {31'h0, o_busy}, 32'h0);
        check("ar_valid", {31'h0, o_valid}, 32'h0);
        check("ar_res", o_result, 32'h0);
        check("ar_flg", {27'h0, o_flags}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        run_op("post_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NX, 28);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/fpu_div_iter.md
FPU_DIV_ITER -- requirements
Module: fpu_div_iter

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset; all ports are listed below.
- i_clk  input  1  rising-edge clock
- i_reset  input  1  asynchronous, active-high reset
- i_start  input  1  launch request; sampled only in IDLE
- i_flush  input  1  kill in-flight operation (pipeline redirect)
- i_rs1_data  input  32  IEEE-754 single dividend
- i_rs2_data  input  32  IEEE-754 single divisor
- o_busy  output  1  high in every state except IDLE; the EX stage stalls on it
- o_valid  output  1  one-cycle result strobe
- o_result  output  32  quotient; feeds the FPU-data input of the ALU/FPU result mux
- o_flags  output  5  {NV,DZ,OF,UF,NX}; valid with o_valid

Function
REQ-002 The FSM SHALL have five states: IDLE, PREP, ITER, ROUND, DONE.
REQ-003 IDLE->PREP SHALL occur on the edge that samples i_start=1; i_start in any other state SHALL be ignored.
REQ-004 PREP SHALL unpack operands, treat subnormal inputs as signed zero (DAZ), and classify special cases.
REQ-005 A special case SHALL go PREP->DONE; otherwise PREP->ITER with a 5-bit counter cleared to 0.
REQ-006 ITER SHALL perform one restoring radix-2 quotient bit per cycle for 26 cycles (24 mantissa + guard + round bits), then go to ROUND.
REQ-007 The sticky bit SHALL be the OR of the final remainder.
REQ-008 Exponent SHALL be computed as 10-bit signed: expA-expB+127, minus 1 if normalisation shifts.
REQ-009 ROUND SHALL apply round-to-nearest-even only, then go to DONE.
REQ-010 Rounding carry-out SHALL renormalise and increment the exponent.
REQ-011 On overflow (exp>=255) the result SHALL be signed infinity with OF|NX.
REQ-012 On underflow (exp<=0) the result SHALL be signed zero with UF|NX (FTZ).
REQ-013 NX SHALL be set whenever guard|round|sticky is 1.
REQ-014 DONE SHALL assert o_valid for exactly one cycle, register o_result/o_flags, and go to IDLE.
REQ-015 Normal-path latency: if start is sampled at edge n, o_valid SHALL be high between edges n+28 and n+29.
REQ-016 Special-case latency: o_valid SHALL be high between edges n+1 and n+2.
REQ-017 The next i_start SHALL be accepted no earlier than edge n+30 (normal) or n+3 (special).
REQ-018 Special-case results SHALL be as follows (s = signA xor signB):
- any NaN operand: 0x7FC00000; NV set if either operand is a signalling NaN
- 0/0 or inf/inf: 0x7FC00000 with NV
- finite nonzero / 0: signed infinity with DZ
- inf/finite: signed infinity, no flags
- finite/inf or 0/finite: signed zero, no flags
REQ-019 The result sign SHALL be s in every case except canonical NaN.
REQ-020 i_flush=1 in any non-IDLE state SHALL force IDLE on the next edge with no o_valid pulse; i_flush in IDLE has no effect.
REQ-021 i_flush SHALL take priority over DONE completion.
REQ-022 o_result and o_flags SHALL hold their last values until the next DONE.

Reset
REQ-023 Asserting i_reset SHALL immediately set state=IDLE, counter=0, o_valid=0, o_busy=0, o_result=0x00000000, o_flags=0, and clear all datapath registers.
REQ-024 Reset mid-operation SHALL abandon the operation silently.
REQ-025 After reset deasserts, the first i_start SHALL be accepted at the next edge.

Structure
REQ-026 The shared package fpu_pkg SHALL hold:
- the state enum
- the FDIV opcode constant 5'b01101
- CANON_NAN = 32'h7FC00000
- flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0
- exponent bias 127
REQ-027 Rounding, overflow/underflow handling and packing SHALL live in one combinational sub-module, fpu_div_round; the FSM and iteration datapath stay in fpu_div_iter.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000, flags 0, o_valid at edge n+28
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flags NX only
- 0x3F800000 / 0x00000000 -> 0x7F800000 DZ at n+1; 0x00000000 / 0x80000000 -> 0x7FC00000 NV
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 OF|NX; 0x00800000 / 0x40000000 -> 0x00000000 UF|NX
- i_flush at ITER cycle 10 -> IDLE next edge, no o_valid, o_result unchanged; i_start while busy -> ignored
- i_reset asserted asynchronously mid-ITER -> all outputs zero immediately; new start completes with correct result
